// File: rtl/bcd_timer_counter_if.sv
// Control and count bus of the BCD elapsed-time counter.
// The master drives enable/clear; the counter (slave) returns the count and status flags.
interface bcd_timer_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  clear;
  logic [4*DIGITS-1:0]   bcd;
  logic                  carry_out;
  logic                  overflow;

  modport master (
    output en, clear,
    input  bcd, carry_out, overflow
  );

  modport slave (
    input  en, clear,
    output bcd, carry_out, overflow
  );
endinterface

// File: rtl/bcd_timer_counter.sv
// Multi-digit BCD counter with a clock prescaler, synchronous clear and
// selectable wrap/saturate behaviour at all-9s. All outputs are registered.
module bcd_timer_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  bcd_timer_counter_if.slave bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]         pre;
  logic                  inc;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [4*DIGITS-1:0]   bcd_nxt;
  logic                  all9;
  logic                  carry_q;
  logic                  ovf_q;

  // One increment request per PRESCALE enabled cycles.
  always_comb begin
    inc = bus.en && (pre == PRE_LAST);
  end

  // Ripple decimal carry: a digit advances only when every lower digit is 9.
  always_comb begin
    logic run;
    bcd_nxt = bcd_q;
    run     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (run) begin
        bcd_nxt[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd9) ? 4'd0 : bcd_q[4*i +: 4] + 4'd1;
      end
      run = run && (bcd_q[4*i +: 4] == 4'd9);
    end
    all9 = run;
  end

  // Prescaler, count register and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre     <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      pre     <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      if (bus.en) begin
        pre <= inc ? '0 : pre + PW'(1);
      end
      if (inc) begin
        if (all9) begin
          ovf_q <= 1'b1;
          if (SATURATE == 0) begin
            bcd_q   <= '0;
            carry_q <= 1'b1;
          end
        end else begin
          bcd_q <= bcd_nxt;
        end
      end
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Directed bench for bcd_timer_counter across four parameter sets sharing
// one clock and reset.
module tb_bcd_timer_counter;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  bcd_timer_counter_if #(.DIGITS(4)) if0 ();
  bcd_timer_counter_if #(.DIGITS(2)) if1 ();
  bcd_timer_counter_if #(.DIGITS(2)) if2 ();
  bcd_timer_counter_if #(.DIGITS(4)) if3 ();

  bcd_timer_counter #(.DIGITS(4), .PRESCALE(1), .SATURATE(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  bcd_timer_counter #(.DIGITS(2), .PRESCALE(1), .SATURATE(0)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  bcd_timer_counter #(.DIGITS(2), .PRESCALE(1), .SATURATE(1)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  bcd_timer_counter #(.DIGITS(4), .PRESCALE(5), .SATURATE(0)) u3 (.clk(clk), .reset_n(reset_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [15:0] b, input logic c, input logic o);
    chk({tag, ".bcd"}, if0.bcd, b);
    chk({tag, ".carry"}, {15'd0, if0.carry_out}, {15'd0, c});
    chk({tag, ".ovf"}, {15'd0, if0.overflow}, {15'd0, o});
  endtask

  initial begin
    logic [15:0] exp1 [12];
    exp1 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
             16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'h0012};
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    if0.en = 1'b0; if0.clear = 1'b0;
    if1.en = 1'b0; if1.clear = 1'b0;
    if2.en = 1'b0; if2.clear = 1'b0;
    if3.en = 1'b0; if3.clear = 1'b0;

    // Reset state
    step(); step();
    chk0("rst.u0", 16'h0000, 1'b0, 1'b0);
    chk("rst.u1.bcd", {8'd0, if1.bcd}, 16'h0000);
    chk("rst.u3.bcd", if3.bcd, 16'h0000);
    reset_n = 1'b1;
    step();

    // Decimal counting across the first digit boundary
    if0.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk0("cnt", exp1[i], 1'b0, 1'b0);
    end
    if0.en = 1'b0;
    step();
    chk0("hold", 16'h0012, 1'b0, 1'b0);

    // Two-digit wrap versus saturate
    if1.en = 1'b1;
    if2.en = 1'b1;
    repeat (98) step();
    chk("pre98.u1", {8'd0, if1.bcd}, 16'h0098);
    chk("pre98.u2", {8'd0, if2.bcd}, 16'h0098);
    step();
    chk("at99.u1", {8'd0, if1.bcd}, 16'h0099);
    chk("at99.u1.c", {15'd0, if1.carry_out}, 16'd0);
    chk("at99.u1.o", {15'd0, if1.overflow}, 16'd0);
    chk("at99.u2.o", {15'd0, if2.overflow}, 16'd0);
    step();
    chk("wrap.u1", {8'd0, if1.bcd}, 16'h0000);
    chk("wrap.u1.c", {15'd0, if1.carry_out}, 16'd1);
    chk("wrap.u1.o", {15'd0, if1.overflow}, 16'd1);
    if1.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sat.u2", {8'd0, if2.bcd}, 16'h0099);
      chk("sat.u2.c", {15'd0, if2.carry_out}, 16'd0);
      chk("sat.u2.o", {15'd0, if2.overflow}, 16'd1);
      step();
      chk("post.u1", {8'd0, if1.bcd}, 16'h0000);
      chk("post.u1.c", {15'd0, if1.carry_out}, 16'd0);
      chk("post.u1.o", {15'd0, if1.overflow}, 16'd1);
    end
    chk("sat5.u2", {8'd0, if2.bcd}, 16'h0099);
    if2.en = 1'b0;

    // Prescaler: one increment per five enabled cycles, frozen while disabled
    if3.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("ps", if3.bcd, (i < 5) ? 16'h0000 : ((i < 10) ? 16'h0001 : 16'h0002));
    end
    step(); step();
    if3.en = 1'b0;
    repeat (3) step();
    chk("ps.freeze", if3.bcd, 16'h0002);
    if3.en = 1'b1;
    step(); chk("ps.res1", if3.bcd, 16'h0002);
    step(); chk("ps.res2", if3.bcd, 16'h0002);
    step(); chk("ps.res3", if3.bcd, 16'h0003);
    // Clear mid-prescale restarts the prescaler
    step(); step();
    if3.clear = 1'b1;
    step();
    chk("ps.clr", if3.bcd, 16'h0000);
    if3.clear = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("ps.restart", if3.bcd, (i < 5) ? 16'h0000 : 16'h0001);
    end
    if3.en = 1'b0;

    // Four-digit wrap, then clear at 0457 with an increment due
    if0.en = 1'b1;
    repeat (9987) step();
    chk0("u0.9999", 16'h9999, 1'b0, 1'b0);
    step();
    chk0("u0.wrap", 16'h0000, 1'b1, 1'b1);
    repeat (457) step();
    chk0("u0.0457", 16'h0457, 1'b0, 1'b1);
    if0.clear = 1'b1;
    step();
    chk0("u0.clr", 16'h0000, 1'b0, 1'b0);
    if0.clear = 1'b0;
    step();
    chk0("u0.after", 16'h0001, 1'b0, 1'b0);

    // Asynchronous reset between edges
    if1.en = 1'b1;
    repeat (3) step();
    chk("u1.pre", {8'd0, if1.bcd}, 16'h0003);
    chk("u1.pre.o", {15'd0, if1.overflow}, 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk0("arst.u0", 16'h0000, 1'b0, 1'b0);
    chk("arst.u1", {8'd0, if1.bcd}, 16'h0000);
    chk("arst.u1.o", {15'd0, if1.overflow}, 16'd0);
    chk("arst.u2", {8'd0, if2.bcd}, 16'h0000);
    step(); step();
    chk0("arst.hold", 16'h0000, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    chk0("arst.rel", 16'h0001, 1'b0, 1'b0);
    if0.en = 1'b0;
    if1.en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
